// File: rtl/svm_loader_pkg.sv
// Shared types and constants for the SVM frame loader: FSM state encoding,
// default frame geometry and an index-width helper.
package svm_loader_pkg;

    localparam int DEF_INPUT_W    = 4;
    localparam int DEF_N_FEATURES = 21;
    localparam int FRAME_W        = DEF_INPUT_W * DEF_N_FEATURES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } loader_state_t;

    // Width of a counter that indexes n items (at least one bit).
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/feature_shadow_buffer.sv
// Assembles one frame from the beat stream into a shadow register, checks
// framing against s_last and flags a complete frame with o_shadow_full.
module feature_shadow_buffer
    import svm_loader_pkg::*;
#(
    parameter int inputWidth = 4,
    parameter int N_features = 21
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_s_valid,
    input  logic [inputWidth-1:0]            i_s_data,
    input  logic                             i_s_last,
    output logic                             o_s_ready,
    input  logic                             i_take,
    output logic [inputWidth*N_features-1:0] o_shadow,
    output logic                             o_shadow_full,
    output logic                             o_frame_err
);

    localparam int IW = idx_width(N_features);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_features - 1);

    logic [IW-1:0]         r_idx;
    logic [inputWidth-1:0] r_shadow [N_features];
    logic                  r_full;
    logic                  r_err;

    logic w_accept;
    logic w_at_end;
    logic w_good_end;
    logic w_bad_end;

    // No beat is accepted while a complete frame waits, so the shadow
    // contents cannot change underneath a pending commit.
    assign w_accept   = i_s_valid && !r_full;
    assign w_at_end   = (r_idx == LAST_IDX);
    assign w_good_end = w_accept && i_s_last && w_at_end;
    assign w_bad_end  = w_accept && (i_s_last != w_at_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_accept) begin
            if (i_s_last || w_at_end) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_bad_end;
            if (i_take) begin
                r_full <= 1'b0;
            end else if (w_good_end) begin
                r_full <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_features; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shadow[gi] <= '0;
                end else if (w_accept && (r_idx == IW'(gi))) begin
                    r_shadow[gi] <= i_s_data;
                end
            end
            assign o_shadow[gi*inputWidth +: inputWidth] = r_shadow[gi];
        end
    endgenerate

    assign o_s_ready     = !r_full;
    assign o_shadow_full = r_full;
    assign o_frame_err   = r_err;

endmodule

// File: rtl/svm_frame_loader.sv
// Front end of the sequential SVM classifier: commits a streamed frame to the
// feature bus, runs the classifier once per frame and holds its result.
module svm_frame_loader
    import svm_loader_pkg::*;
#(
    parameter int inputWidth = 4,
    parameter int N_features = 21,
    parameter int classWidth = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             s_valid,
    input  logic [inputWidth-1:0]            s_data,
    input  logic                             s_last,
    output logic                             s_ready,
    output logic [inputWidth*N_features-1:0] feat_out,
    output logic                             cls_rst_n,
    input  logic                             cls_ready,
    input  logic [classWidth-1:0]            cls_class,
    output logic                             res_valid,
    output logic [classWidth-1:0]            res_class,
    input  logic                             res_ready,
    output logic                             frame_err
);

    localparam int FW = inputWidth * N_features;

    loader_state_t         r_state;
    loader_state_t         w_state_next;
    logic                  r_first_run;
    logic [classWidth-1:0] r_pending;
    logic [FW-1:0]         r_feat;
    logic                  r_cls_rst_n;
    logic                  r_res_valid;
    logic [classWidth-1:0] r_res_class;

    logic          w_commit;
    logic          w_capture;
    logic          w_slot_free;
    logic          w_load_res;
    logic [FW-1:0] w_shadow;
    logic          w_shadow_full;

    feature_shadow_buffer #(
        .inputWidth (inputWidth),
        .N_features (N_features)
    ) u_shadow (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_s_valid     (s_valid),
        .i_s_data      (s_data),
        .i_s_last      (s_last),
        .o_s_ready     (s_ready),
        .i_take        (w_commit),
        .o_shadow      (w_shadow),
        .o_shadow_full (w_shadow_full),
        .o_frame_err   (frame_err)
    );

    assign w_commit    = (r_state == IDLE) && w_shadow_full;
    // The classifier leaves reset on the first RUN cycle, so its ready line
    // is only trusted from the second RUN cycle onward.
    assign w_capture   = (r_state == RUN) && !r_first_run && cls_ready;
    assign w_slot_free = !r_res_valid || res_ready;
    assign w_load_res  = (r_state == DRAIN) && w_slot_free;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_commit)    w_state_next = RUN;
            RUN:     if (w_capture)   w_state_next = DRAIN;
            DRAIN:   if (w_slot_free) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cls_rst_n <= 1'b0;
            r_first_run <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cls_rst_n <= (w_state_next == RUN);
            r_first_run <= w_commit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feat    <= '0;
            r_pending <= '0;
        end else begin
            if (w_commit) begin
                r_feat <= w_shadow;
            end
            if (w_capture) begin
                r_pending <= cls_class;
            end
        end
    end

    // A reload in the same cycle as a consume keeps res_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_class <= '0;
        end else if (w_load_res) begin
            r_res_valid <= 1'b1;
            r_res_class <= r_pending;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign feat_out  = r_feat;
    assign cls_rst_n = r_cls_rst_n;
    assign res_valid = r_res_valid;
    assign res_class = r_res_class;

endmodule
